// File: rtl/cache_line_fill_engine_pkg.sv
// rtl/cache_line_fill_engine_pkg.sv - package cache_pkg: fill FSM states, default parameters, width helpers
package cache_pkg;

   localparam int DEF_ADDR_W     = 32;
   localparam int DEF_DATA_W     = 32;
   localparam int DEF_LINE_WORDS = 8;
   localparam int DEF_INDEX_W    = 9;

   typedef enum logic [2:0] {
      IDLE,
      WR_THRU,
      RD_REQ,
      RD_WAIT,
      UPDATE
   } fill_state_t;

   function automatic int off_w(input int line_words);
      return $clog2(line_words);
   endfunction

   // Tag sits above index, word offset and the two byte-offset bits.
   function automatic int tag_w(input int addr_w, input int index_w, input int line_words);
      return addr_w - index_w - $clog2(line_words) - 2;
   endfunction

endpackage

// File: rtl/cache_line_fill_engine_if.sv
// rtl/cache_line_fill_engine_if.sv - miss request port and L2 request/response bus of the fill engine
interface cache_line_fill_engine_if import cache_pkg::*; #(
   parameter int ADDR_W = DEF_ADDR_W,
   parameter int DATA_W = DEF_DATA_W
);
   logic              miss_valid;
   logic              miss_ready;
   logic              miss_is_wr;
   logic [ADDR_W-1:0] miss_addr;
   logic [DATA_W-1:0] miss_wdata;
   logic              l2_req_valid;
   logic              l2_req_ready;
   logic              l2_req_we;
   logic [ADDR_W-1:0] l2_req_addr;
   logic [DATA_W-1:0] l2_req_wdata;
   logic              l2_rsp_valid;
   logic [DATA_W-1:0] l2_rsp_data;

   modport master (
      input  miss_valid, miss_is_wr, miss_addr, miss_wdata,
      input  l2_req_ready, l2_rsp_valid, l2_rsp_data,
      output miss_ready, l2_req_valid, l2_req_we, l2_req_addr, l2_req_wdata
   );

   modport slave (
      output miss_valid, miss_is_wr, miss_addr, miss_wdata,
      output l2_req_ready, l2_rsp_valid, l2_rsp_data,
      input  miss_ready, l2_req_valid, l2_req_we, l2_req_addr, l2_req_wdata
   );

endinterface

// File: rtl/cache_line_fill_engine_buf.sv
// rtl/cache_line_fill_engine_buf.sv - cache_line_buf: line buffer that merges the store word over L2 data
module cache_line_buf import cache_pkg::*; #(
   parameter  int DATA_W     = DEF_DATA_W,
   parameter  int LINE_WORDS = DEF_LINE_WORDS,
   localparam int OFF_W      = off_w(LINE_WORDS)
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         wr_en,
   input  logic [OFF_W-1:0]             wr_idx,
   input  logic [DATA_W-1:0]            rsp_data,
   input  logic                         merge_en,
   input  logic [OFF_W-1:0]             merge_idx,
   input  logic [DATA_W-1:0]            merge_data,
   output logic [LINE_WORDS*DATA_W-1:0] line
);
   logic [DATA_W-1:0] words [LINE_WORDS];

   // A store miss keeps its own word; the stale L2 copy of that slot is dropped.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < LINE_WORDS; i++) words[i] <= '0;
      end else if (wr_en) begin
         words[wr_idx] <= (merge_en && (wr_idx == merge_idx)) ? merge_data : rsp_data;
      end
   end

   for (genvar g = 0; g < LINE_WORDS; g++) begin : g_line
      assign line[g*DATA_W +: DATA_W] = words[g];
   end

endmodule

// File: rtl/cache_line_fill_engine.sv
// rtl/cache_line_fill_engine.sv - miss-driven L2 line fill FSM with write-through of store misses
// Define CACHE_FILL_CRITICAL_WORD_FIRST_EN to start each fill at the missed word and wrap.
module cache_line_fill_engine import cache_pkg::*; #(
   parameter  int ADDR_W     = DEF_ADDR_W,
   parameter  int DATA_W     = DEF_DATA_W,
   parameter  int LINE_WORDS = DEF_LINE_WORDS,
   parameter  int INDEX_W    = DEF_INDEX_W,
   localparam int OFF_W      = off_w(LINE_WORDS),
   localparam int TAG_W      = tag_w(ADDR_W, INDEX_W, LINE_WORDS)
) (
   input  logic                         clk,
   input  logic                         rst_n,
   cache_line_fill_engine_if.master     bus,
   output logic                         fill_valid,
   output logic [LINE_WORDS*DATA_W-1:0] fill_line,
   output logic [TAG_W:0]               fill_tag_vld,
   output logic                         busy
);
   fill_state_t       state, state_nxt;
   logic [ADDR_W-3:0] waddr_q;
   logic              is_wr_q;
   logic [DATA_W-1:0] wdata_q;
   logic [OFF_W-1:0]  cnt_q;
   logic [OFF_W-1:0]  done_q;
   logic              tag_vld_q;
   logic              capture;
   logic              rsp_take;
   logic              last_word;
   logic              unused_byte_bits;

   assign unused_byte_bits = ^bus.miss_addr[1:0];
   assign capture   = (state == IDLE) && bus.miss_valid;
   assign rsp_take  = (state == RD_WAIT) && bus.l2_rsp_valid;
   assign last_word = (done_q == OFF_W'(LINE_WORDS - 1));

   always_ff @(posedge clk) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt        = state;
      bus.miss_ready   = 1'b0;
      bus.l2_req_valid = 1'b0;
      bus.l2_req_we    = 1'b0;
      bus.l2_req_addr  = '0;
      bus.l2_req_wdata = '0;
      case (state)
         IDLE: begin
            bus.miss_ready = 1'b1;
            if (bus.miss_valid) state_nxt = bus.miss_is_wr ? WR_THRU : RD_REQ;
         end
         WR_THRU: begin
            bus.l2_req_valid = 1'b1;
            bus.l2_req_we    = 1'b1;
            bus.l2_req_addr  = {2'b00, waddr_q};
            bus.l2_req_wdata = wdata_q;
            if (bus.l2_req_ready) state_nxt = RD_REQ;
         end
         RD_REQ: begin
            bus.l2_req_valid = 1'b1;
            bus.l2_req_addr  = {2'b00, waddr_q[ADDR_W-3:OFF_W], cnt_q};
            if (bus.l2_req_ready) state_nxt = RD_WAIT;
         end
         RD_WAIT: begin
            if (bus.l2_rsp_valid) state_nxt = last_word ? UPDATE : RD_REQ;
         end
         UPDATE:  state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // cnt_q addresses the slot, done_q counts words so a wrapped fill still ends after one line.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         waddr_q   <= '0;
         is_wr_q   <= 1'b0;
         wdata_q   <= '0;
         cnt_q     <= '0;
         done_q    <= '0;
         tag_vld_q <= 1'b0;
      end else if (capture) begin
         waddr_q   <= bus.miss_addr[ADDR_W-1:2];
         is_wr_q   <= bus.miss_is_wr;
         wdata_q   <= bus.miss_wdata;
         done_q    <= '0;
         tag_vld_q <= 1'b1;
`ifdef CACHE_FILL_CRITICAL_WORD_FIRST_EN
         cnt_q     <= bus.miss_addr[2 +: OFF_W];
`else
         cnt_q     <= '0;
`endif
      end else if (rsp_take) begin
         cnt_q  <= cnt_q + 1'b1;
         done_q <= done_q + 1'b1;
      end
   end

   cache_line_buf #(
      .DATA_W     (DATA_W),
      .LINE_WORDS (LINE_WORDS)
   ) u_line_buf (
      .clk        (clk),
      .rst_n      (rst_n),
      .wr_en      (rsp_take),
      .wr_idx     (cnt_q),
      .rsp_data   (bus.l2_rsp_data),
      .merge_en   (is_wr_q),
      .merge_idx  (waddr_q[OFF_W-1:0]),
      .merge_data (wdata_q),
      .line       (fill_line)
   );

   assign fill_valid   = (state == UPDATE);
   assign fill_tag_vld = {tag_vld_q, waddr_q[ADDR_W-3 -: TAG_W]};
   assign busy         = (state != IDLE);

endmodule

// File: doc/cache_line_fill_engine.md
CACHE_LINE_FILL_ENGINE -- requirements
Module: cache_line_fill_engine

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, byte-address width.
REQ-002 SHALL have parameter DATA_W, default 32, word width; fixed at 32 in this generation.
REQ-003 SHALL have parameter LINE_WORDS, default 8, words per line; power of two, 2..16.
REQ-004 SHALL have parameter INDEX_W, default 9, set-index bits; TAG_W = ADDR_W - INDEX_W - log2(LINE_WORDS) - 2.
REQ-005 SHALL have ports clk (in, 1, clock) and rst_n (in, 1, reset: synchronous, active-low).
REQ-006 SHALL have ports miss_valid (in, 1, miss request), miss_ready (out, 1, engine idle), miss_is_wr (in, 1, write miss), miss_addr (in, ADDR_W, byte address), miss_wdata (in, DATA_W, store data).
REQ-007 SHALL have ports l2_req_valid (out, 1), l2_req_ready (in, 1), l2_req_we (out, 1), l2_req_addr (out, ADDR_W, word address = {2'b00, addr[ADDR_W-1:2]}), l2_req_wdata (out, DATA_W).
REQ-008 SHALL have ports l2_rsp_valid (in, 1) and l2_rsp_data (in, DATA_W).
REQ-009 SHALL have ports fill_valid (out, 1, one-cycle pulse), fill_line (out, LINE_WORDS*DATA_W, word 0 in LSBs), fill_tag_vld (out, TAG_W+1, {1'b1, tag}), busy (out, 1).

Function
REQ-010 SHALL implement the FSM states IDLE, WR_THRU, RD_REQ, RD_WAIT and UPDATE.
REQ-011 SHALL assert miss_ready only in IDLE, capture miss_addr, miss_is_wr and miss_wdata on miss_valid&&miss_ready, and ignore requests in all other states.
REQ-012 SHALL go IDLE->WR_THRU on a write miss and IDLE->RD_REQ on a read miss.
REQ-013 SHALL, in WR_THRU, drive l2_req_we=1 with the miss word address and miss_wdata, then enter RD_REQ on handshake.
REQ-014 SHALL, in RD_REQ, drive l2_req_we=0 with word address {line base, word counter}, and enter RD_WAIT on l2_req_valid&&l2_req_ready.
REQ-015 SHALL hold l2_req_valid, addr, we and wdata stable until ready; at most one L2 request outstanding.
REQ-016 SHALL, in RD_WAIT on l2_rsp_valid, store data at the counter slot and increment the counter modulo LINE_WORDS; RD_REQ follows if words remain, else UPDATE.
REQ-017 SHALL, on a write miss, write miss_wdata instead of l2_rsp_data into the slot equal to miss_addr word offset.
REQ-018 SHALL ignore l2_rsp_valid outside RD_WAIT.
REQ-019 SHALL, in UPDATE, pulse fill_valid for exactly one cycle with fill_line/fill_tag_vld stable, then return to IDLE.
REQ-020 SHALL hold fill_line and fill_tag_vld until the next capture.
REQ-021 SHALL make busy = (state != IDLE).
REQ-022 SHALL achieve minimum miss latency, capture to fill_valid, of 2*LINE_WORDS+1 cycles for a read miss and +1 with zero-wait L2 for a write miss.

Reset
REQ-023 SHALL, on rst_n low at any clock including mid-fill, enter IDLE, clear the counter, line buffer and captured miss, drive all outputs 0 except miss_ready=1, and issue no further L2 traffic.

Configuration
REQ-024 SHALL, with CACHE_FILL_CRITICAL_WORD_FIRST_EN defined, start the word counter at the miss word offset and wrap from LINE_WORDS-1 to 0, ending after LINE_WORDS words.
REQ-025 SHALL, with CACHE_FILL_CRITICAL_WORD_FIRST_EN undefined, always start the counter at 0.

Structure
REQ-026 SHALL place the FSM state enum, tag/offset width functions and default parameters in package cache_pkg.
REQ-027 SHALL put the line buffer with its merge-on-write logic in sub-module cache_line_buf.

Verification
REQ-028 SHALL verify a read miss at addr 0x0000_4020 with zero-wait L2 returning 0xA0..0xA7 -> L2 read word addresses 0x1008..0x100F, fill_valid after 17 cycles, fill_line words = A0..A7, fill_tag_vld = {1,0x00001}.
REQ-029 SHALL verify a write miss at 0x0000_4024 with wdata 0xDEADBEEF -> L2 write to 0x1009 first, then 8 reads, and fill_line word1 = 0xDEADBEEF.
REQ-030 SHALL verify that l2_req_ready held low 5 cycles -> request fields stable, no counter advance, fill completes correctly.
REQ-031 SHALL verify that miss_valid asserted while busy -> miss_ready=0 and the request is not captured, while the in-flight fill is unaffected.
REQ-032 SHALL verify that rst_n low after the 3rd response -> next cycle IDLE, miss_ready=1, no fill_valid, and the next miss restarts at word 0.
REQ-033 SHALL verify, with CACHE_FILL_CRITICAL_WORD_FIRST_EN and a miss at offset 6, a read order of 6,7,0,1,2,3,4,5 and a correct line.
